// File: rtl/irq_pkg.sv
// Shared interrupt-source types and the bridge address map.
// No logic: state encoding, range constants and small combinational helpers.
package irq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COUNT   = 3'd1,
    ST_ASSERT  = 3'd2,
    ST_HOLDOFF = 3'd3,
    ST_DONE    = 3'd4
  } irq_state_t;

  // Bridge decode ranges; the acknowledge window is the single PR word.
  localparam logic [31:0] BEGIN_DM  = 32'h0000_0000;
  localparam logic [31:0] END_DM    = 32'h0000_2fff;
  localparam logic [31:0] BEGIN_TC0 = 32'h0000_7f00;
  localparam logic [31:0] END_TC0   = 32'h0000_7f0b;
  localparam logic [31:0] BEGIN_TC1 = 32'h0000_7f10;
  localparam logic [31:0] END_TC1   = 32'h0000_7f1b;
  localparam logic [31:0] BEGIN_PR  = 32'h0000_7f20;
  localparam logic [31:0] END_PR    = 32'h0000_7f23;

  localparam logic [31:0] WORD_MASK = 32'hffff_fffc;

  // Word match ignores the byte offset; any nonzero byte enable is a store.
  function automatic logic ack_hit(input logic [31:0] addr,
                                   input logic [31:0] base,
                                   input logic [3:0]  byteen);
    return (((addr ^ base) & WORD_MASK) == 32'd0) && (byteen != 4'd0);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hffff) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/irq_source_if.sv
// Acknowledge window plus interrupt line between the CPU bridge and the source.
// Plain wires, no handshake: a store is a single-cycle nonzero byte enable.
interface irq_source_if;
  logic [31:0] m_int_addr;
  logic [3:0]  m_int_byteen;
  logic        interrupt;

  modport master (
    output m_int_addr,
    output m_int_byteen,
    input  interrupt
  );

  modport slave (
    input  m_int_addr,
    input  m_int_byteen,
    output interrupt
  );
endinterface

// File: rtl/irq_down_counter.sv
// 16-bit loadable down-counter; load wins over dec, holds at zero.
// One-cycle update latency, zero flag is combinational from the register.
module irq_down_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        dec,
  output logic        zero
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != 16'd0)) begin
      cnt_d = cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 16'd0);

endmodule

// File: rtl/irq_source.sv
// Programmable interrupt source: raise after DELAY, hold until acked, re-arm after HOLDOFF.
// Interrupt rises DELAY edges after enable is sampled; no backpressure, acks are never stalled.
module irq_source
  import irq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7f20,
  parameter int unsigned DELAY     = 10,
  parameter int unsigned HOLDOFF   = 2,
  parameter int unsigned MAX_IRQ   = 0,
  parameter int unsigned PULSE     = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  irq_source_if.slave  bus,
  output logic [15:0]  irq_count,
  output logic [15:0]  ack_count,
  output logic         spurious_ack,
  output logic         busy
);

  localparam logic [15:0] DELAY_LD  = 16'(DELAY - 1);
  localparam logic [15:0] HOLD_LD   = (HOLDOFF == 0) ? 16'd0 : 16'(HOLDOFF - 1);
  localparam logic [15:0] MAX_IRQ_W = 16'(MAX_IRQ);
  localparam logic        LIMITED   = (MAX_IRQ != 0);
  localparam logic        USE_HOLD  = (HOLDOFF != 0);
  localparam logic        PULSE_M   = (PULSE != 0);

  irq_state_t  state_q, state_d;
  logic [15:0] irq_count_q, irq_count_d;
  logic [15:0] ack_count_q, ack_count_d;
  logic        interrupt_q, interrupt_d;
  logic        spurious_q, spurious_d;

  logic        hit;
  logic        cnt_load;
  logic [15:0] cnt_load_val;
  logic        cnt_dec;
  logic        cnt_zero;

  assign hit = ack_hit(bus.m_int_addr, BASE_ADDR, bus.m_int_byteen);

  irq_down_counter u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    irq_count_d  = irq_count_q;
    ack_count_d  = ack_count_q;
    cnt_load     = 1'b0;
    cnt_load_val = DELAY_LD;
    cnt_dec      = 1'b0;
    // Only the ASSERT state consumes a hit; everywhere else it is reported.
    spurious_d   = hit && (state_q != ST_ASSERT);

    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d  = ST_COUNT;
          cnt_load = 1'b1;
        end
      end

      ST_COUNT: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (cnt_zero) begin
          state_d     = ST_ASSERT;
          irq_count_d = sat_inc16(irq_count_q);
        end else begin
          cnt_dec = 1'b1;
        end
      end

      // enable is deliberately ignored: an issued interrupt always needs its ack.
      ST_ASSERT: begin
        if (hit) begin
          ack_count_d = sat_inc16(ack_count_q);
          if (LIMITED && (irq_count_q == MAX_IRQ_W)) begin
            state_d = ST_DONE;
          end else if (USE_HOLD) begin
            state_d      = ST_HOLDOFF;
            cnt_load     = 1'b1;
            cnt_load_val = HOLD_LD;
          end else if (enable) begin
            state_d  = ST_COUNT;
            cnt_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_HOLDOFF: begin
        if (cnt_zero) begin
          if (enable) begin
            state_d  = ST_COUNT;
            cnt_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_DONE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered line follows the next state; pulse mode only marks ASSERT entry.
    interrupt_d = (state_d == ST_ASSERT) && (!PULSE_M || (state_q != ST_ASSERT));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      irq_count_q <= 16'd0;
      ack_count_q <= 16'd0;
      interrupt_q <= 1'b0;
      spurious_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      irq_count_q <= irq_count_d;
      ack_count_q <= ack_count_d;
      interrupt_q <= interrupt_d;
      spurious_q  <= spurious_d;
    end
  end

  assign bus.interrupt = interrupt_q;
  assign irq_count     = irq_count_q;
  assign ack_count     = ack_count_q;
  assign spurious_ack  = spurious_q;
  assign busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule

// File: tb/tb_irq_source.sv
// Directed bench for irq_source: four parameterisations share one acknowledge bus.
// Expected values are queued before each step and popped when the DUT answers.
module tb_irq_source;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [3:0]  byteen = 4'd0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  irq_source_if bus0 ();
  irq_source_if bus1 ();
  irq_source_if bus2 ();
  irq_source_if bus3 ();

  assign bus0.m_int_addr = addr;  assign bus0.m_int_byteen = byteen;
  assign bus1.m_int_addr = addr;  assign bus1.m_int_byteen = byteen;
  assign bus2.m_int_addr = addr;  assign bus2.m_int_byteen = byteen;
  assign bus3.m_int_addr = addr;  assign bus3.m_int_byteen = byteen;

  logic [3:0]       irq_w, spur_w, busy_w;
  logic [3:0][15:0] irqc_w, ackc_w;

  assign irq_w = {bus3.interrupt, bus2.interrupt, bus1.interrupt, bus0.interrupt};

  // 0: defaults, 1: MAX_IRQ=2, 2: pulse mode, 3: DELAY=1 HOLDOFF=0
  irq_source u_dut0 (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus0),
    .irq_count(irqc_w[0]), .ack_count(ackc_w[0]), .spurious_ack(spur_w[0]), .busy(busy_w[0])
  );
  irq_source #(.MAX_IRQ(2)) u_dut1 (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus1),
    .irq_count(irqc_w[1]), .ack_count(ackc_w[1]), .spurious_ack(spur_w[1]), .busy(busy_w[1])
  );
  irq_source #(.PULSE(1)) u_dut2 (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus2),
    .irq_count(irqc_w[2]), .ack_count(ackc_w[2]), .spurious_ack(spur_w[2]), .busy(busy_w[2])
  );
  irq_source #(.DELAY(1), .HOLDOFF(0)) u_dut3 (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus3),
    .irq_count(irqc_w[3]), .ack_count(ackc_w[3]), .spurious_ack(spur_w[3]), .busy(busy_w[3])
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic push(input string tag, input logic [31:0] e);
    exp_t item;
    item.tag = tag;
    item.exp = e;
    sb.push_back(item);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t item;
    item = sb.pop_front();
    checks++;
    assert (obs === item.exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", item.tag, obs, item.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hit_write(input logic [31:0] a, input logic [3:0] be);
    addr   = a;
    byteen = be;
    tick();
    addr   = 32'd0;
    byteen = 4'd0;
  endtask

  // Edge number of the first high sample, or all-ones if the budget expires.
  task automatic wait_rise(input int idx, input int budget, output logic [31:0] at);
    at = 32'hffff_ffff;
    for (int i = 0; i < budget && at == 32'hffff_ffff; i++) begin
      tick();
      if (irq_w[idx] === 1'b1) at = 32'(cyc);
    end
  endtask

  task automatic count_high(input int idx, input int n, output logic [31:0] hi);
    hi = 32'd0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (irq_w[idx] !== 1'b0) hi++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [31:0] at, hi;
    int e0, a;

    repeat (3) tick();
    push("rst_interrupt", 0);  check(32'(irq_w[0]));
    push("rst_irq_count", 0);  check(32'(irqc_w[0]));
    push("rst_ack_count", 0);  check(32'(ackc_w[0]));
    push("rst_spurious", 0);   check(32'(spur_w[0]));
    push("rst_busy", 0);       check(32'(busy_w[0]));

    // Arm, acknowledge, re-arm on the default instance.
    reset = 1'b0;
    repeat (2) tick();
    enable = 1'b1;
    tick();
    e0 = cyc;
    push("rise1_edge", 32'(e0 + 10));
    wait_rise(0, 40, at);  check(at);
    repeat (4) tick();
    hit_write(32'h7f20, 4'hf);
    a = cyc;
    push("fall_on_ack", 0);    check(32'(irq_w[0]));
    push("ack_count_1", 1);    check(32'(ackc_w[0]));
    push("rise2_edge", 32'(a + 12));
    wait_rise(0, 40, at);  check(at);
    push("irq_count_2", 2);    check(32'(irqc_w[0]));
    push("ack_count_still1", 1); check(32'(ackc_w[0]));

    // Spurious and near-miss writes while counting.
    hit_write(32'h7f20, 4'hf);
    a = cyc;
    repeat (3) tick();
    hit_write(32'h7f20, 4'hf);
    push("spur_in_count", 1);  check(32'(spur_w[0]));
    push("spur_no_ack", 2);    check(32'(ackc_w[0]));
    push("busy_in_count", 1);  check(32'(busy_w[0]));
    tick();
    push("spur_one_cycle", 0); check(32'(spur_w[0]));
    hit_write(32'h7f24, 4'hf);
    push("near_addr_no_spur", 0); check(32'(spur_w[0]));
    hit_write(32'h7f20, 4'h0);
    push("zero_be_no_spur", 0); check(32'(spur_w[0]));
    hit_write(32'h7f23, 4'h1);
    push("byte_off_spur", 1);  check(32'(spur_w[0]));
    push("irq_count_held", 2); check(32'(irqc_w[0]));
    push("rise3_edge", 32'(a + 12));
    wait_rise(0, 40, at);  check(at);

    // Enable dropped in ASSERT: line held until acked, then idle.
    enable = 1'b0;
    repeat (3) tick();
    push("held_no_enable", 1); check(32'(irq_w[0]));
    hit_write(32'h7f20, 4'hf);
    push("fall_no_enable", 0); check(32'(irq_w[0]));
    repeat (2) tick();
    push("idle_after_hold", 0); check(32'(busy_w[0]));
    count_high(0, 30, hi);
    push("no_irq_when_idle", 0); check(hi);

    // Reset one cycle into ASSERT with nonzero counts.
    enable = 1'b1;
    tick();
    e0 = cyc;
    push("rise4_edge", 32'(e0 + 10));
    wait_rise(0, 40, at);  check(at);
    tick();
    reset = 1'b1;
    tick();
    push("rst_mid_irq", 0);    check(32'(irq_w[0]));
    push("rst_mid_irqc", 0);   check(32'(irqc_w[0]));
    push("rst_mid_ackc", 0);   check(32'(ackc_w[0]));
    push("rst_mid_busy", 0);   check(32'(busy_w[0]));

    // Hit on the edge that enters ASSERT is spurious.
    reset = 1'b0;
    tick();
    e0 = cyc;
    repeat (9) tick();
    hit_write(32'h7f20, 4'hf);
    push("entry_hit_spur", 1); check(32'(spur_w[0]));
    push("entry_irq_high", 1); check(32'(irq_w[0]));
    push("entry_no_ack", 0);   check(32'(ackc_w[0]));
    push("entry_edge", 32'(e0 + 10)); check(32'(cyc));
    hit_write(32'h7f20, 4'hf);
    push("entry_then_ack", 1); check(32'(ackc_w[0]));

    // Enable dropped during COUNT.
    do_reset();
    enable = 1'b1;
    repeat (4) tick();
    enable = 1'b0;
    repeat (2) tick();
    push("count_drop_idle", 0); check(32'(busy_w[0]));
    count_high(0, 30, hi);
    push("count_drop_no_irq", 0); check(hi);

    // MAX_IRQ=2 instance reaches DONE.
    do_reset();
    enable = 1'b1;
    tick();
    e0 = cyc;
    push("max_rise1", 32'(e0 + 10));
    wait_rise(1, 40, at);  check(at);
    hit_write(32'h7f20, 4'hf);
    a = cyc;
    push("max_rise2", 32'(a + 12));
    wait_rise(1, 40, at);  check(at);
    hit_write(32'h7f20, 4'hf);
    push("done_busy", 0);      check(32'(busy_w[1]));
    push("done_irq", 0);       check(32'(irq_w[1]));
    push("done_irqc", 2);      check(32'(irqc_w[1]));
    push("done_ackc", 2);      check(32'(ackc_w[1]));
    count_high(1, 100, hi);
    push("done_quiet", 0);     check(hi);
    hit_write(32'h7f20, 4'hf);
    push("done_spur", 1);      check(32'(spur_w[1]));
    push("done_ackc_held", 2); check(32'(ackc_w[1]));

    // Pulse mode with a late acknowledge.
    do_reset();
    enable = 1'b1;
    tick();
    e0 = cyc;
    push("pulse_rise", 32'(e0 + 10));
    wait_rise(2, 40, at);  check(at);
    tick();
    push("pulse_width", 0);    check(32'(irq_w[2]));
    repeat (6) tick();
    push("pulse_busy_wait", 1); check(32'(busy_w[2]));
    hit_write(32'h7f20, 4'hf);
    a = cyc;
    push("pulse_ackc", 1);     check(32'(ackc_w[2]));
    push("pulse_rise2", 32'(a + 12));
    wait_rise(2, 40, at);  check(at);

    // Minimum delay, no hold-off.
    do_reset();
    enable = 1'b1;
    tick();
    e0 = cyc;
    push("d1_rise", 32'(e0 + 1));
    wait_rise(3, 10, at);  check(at);
    hit_write(32'h7f20, 4'hf);
    a = cyc;
    push("d1_fall", 0);        check(32'(irq_w[3]));
    push("d1_rise2", 32'(a + 1));
    wait_rise(3, 10, at);  check(at);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_source.md
# irq_source

Bus-side interrupt source that drives the CPU's external `interrupt` line and is the responder for the interrupt-acknowledge write window (`m_int_addr`/`m_int_byteen`, word at 0x0000_7f20). It raises an interrupt after a programmable delay and holds it until the CPU acknowledges with a store into the window. It then waits a hold-off interval and re-arms. It sits beside the `mips` top in the system bench and in FPGA wrappers, replacing the hand-driven interrupt stimulus.

## Interface
- `BASE_ADDR`, 32'h0000_7f20: word address of the acknowledge window; only bits [31:2] are compared.
- `DELAY`, 10: cycles from arming to interrupt assertion; legal values are 1..65535.
- `HOLDOFF`, 2: cycles after an acknowledge before the delay restarts; legal values are 0..65535.
- `MAX_IRQ`, 0: number of interrupts to issue before stopping; 0 means unlimited.
- `PULSE`, 0: 0 selects level mode (high until acknowledged); 1 selects a one-cycle pulse per interrupt.
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `enable` in 1: arms the source while high.
- `m_int_addr` in 32: acknowledge address from the CPU bridge.
- `m_int_byteen` in 4: acknowledge byte enables; nonzero means a write.
- `interrupt` out 1: interrupt request to the CPU; registered.
- `irq_count` out 16: interrupts issued; saturates at 16'hFFFF.
- `ack_count` out 16: valid acknowledges received; saturates at 16'hFFFF.
- `spurious_ack` out 1: registered one-cycle pulse when a write arrives that is not a valid acknowledge.
- `busy` out 1: high whenever the state is not IDLE or DONE.

## Operation
- `hit` = (`m_int_addr`[31:2] == `BASE_ADDR`[31:2]) && (`m_int_byteen` != 0). It is combinational and sampled at the clock edge.
- State machine states: IDLE, COUNT, ASSERT, HOLDOFF, DONE. A 16-bit down-counter `cnt` serves COUNT and HOLDOFF.
- IDLE:
  - `interrupt` = 0.
  - `enable` high → COUNT with `cnt` = DELAY-1.
- COUNT:
  - `enable` low → IDLE.
  - Otherwise, `cnt` == 0 → ASSERT, `irq_count`++; else `cnt`--.
- ASSERT:
  - `enable` is ignored; an issued interrupt must always be acknowledged.
  - `hit` → `ack_count`++ and `interrupt` clears.
  - After a `hit`, the next state is chosen in this priority order:
    - DONE if MAX_IRQ != 0 and `irq_count` == MAX_IRQ.
    - Otherwise HOLDOFF with `cnt` = HOLDOFF-1 when HOLDOFF > 0.
    - Otherwise COUNT with `cnt` = DELAY-1 when `enable` is high, or IDLE when it is low.
- HOLDOFF:
  - `cnt` == 0 → COUNT with `cnt` = DELAY-1 if `enable` is high, else IDLE.
  - Otherwise `cnt`--.
- DONE: `interrupt` = 0 until reset.
- `interrupt` timing:
  - Level mode: high for exactly the cycles spent in ASSERT.
  - Pulse mode: high only in the first ASSERT cycle; the state still waits in ASSERT for the acknowledge.
- `hit` in any state other than ASSERT → `spurious_ack` pulses for one cycle. No state change and no count change.
- A `hit` sampled on the same edge that enters ASSERT counts as spurious, because the state at that edge was COUNT.

## Timing
- Reset values: state IDLE, `cnt` = 0, `interrupt` = 0, `irq_count` = 0, `ack_count` = 0, `spurious_ack` = 0, `busy` = 0.
- `enable` first sampled high at edge E0 → `interrupt` rises at edge E0+DELAY.
- `hit` at edge A:
  - `interrupt` falls at A.
  - With HOLDOFF = H > 0 and `enable` held high, the next rise is at A+H+DELAY.
  - With H = 0, the next rise is at A+DELAY.
- Reset asserted mid-operation (any state, including ASSERT) → all outputs return to reset values at that edge. A new interrupt rises no earlier than DELAY cycles after `enable` is sampled high following reset release.
- Counter saturation: at 16'hFFFF, further increments hold the value.

## Structure
- Shared package `irq_pkg`:
  - State enum `irq_state_t`.
  - Address-map constants `BEGIN_PR` = 32'h7f20, `END_PR` = 32'h7f23, plus the DM and TC0/TC1 ranges, shared with the bridge decode.
- One sub-module, `irq_down_counter`: 16-bit loadable down-counter with `load`, `load_val`, `dec` inputs and a `zero` output. It is used for both the DELAY and HOLDOFF intervals.

## Test plan
- Arm, acknowledge, re-arm: DELAY=10, HOLDOFF=2, `enable` high at edge 5 → `interrupt` rises at edge 15. A `hit` write (addr 0x7f20, byteen 4'b1111) at edge 20 → `interrupt` falls at 20 and rises again at 32. After the second rise, `irq_count` = 2 and `ack_count` = 1.
- Spurious and near-miss writes: a `hit` during COUNT → `spurious_ack` pulses once and `ack_count` is unchanged. Addr 0x7f24 with byteen 4'b1111 → no pulse. Addr 0x7f20 with byteen 0 → no pulse.
- MAX_IRQ=2: after the second acknowledge → state DONE, `busy` = 0, `interrupt` stays 0 for 100 cycles, and any `hit` gives a `spurious_ack` pulse.
- PULSE=1: `interrupt` is high for exactly 1 cycle. With the acknowledge delayed 8 cycles, no second interrupt appears before the acknowledge plus HOLDOFF+DELAY.
- Reset and enable edge cases:
  - Reset asserted one cycle into ASSERT → `interrupt` is 0 and both counts are 0 at that edge.
  - `enable` dropped during COUNT → IDLE, and no interrupt follows.
  - `enable` dropped during ASSERT → `interrupt` is held until acknowledged, then the state goes to IDLE.
